// File: rtl/sopc_rst_ctrl.sv
// Reset/watchdog controller for openmips_min_sopc: sopc_rst releases STRETCH_CYCLES+2 edges after the
// board reset rises. Internal resets hold it for exactly STRETCH_CYCLES cycles. There is no backpressure.
module sopc_rst_ctrl #(
  parameter int STRETCH_CYCLES = 16,
  parameter int WDT_CYCLES     = 4096,
  parameter int WDT_CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       sopc_rst,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SCW-1:0]    STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);
  localparam logic [WDT_CW-1:0] WDT_LAST     = WDT_CW'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        sync;
  logic [SCW-1:0]    stretch_cnt;
  logic [WDT_CW-1:0] wdt_cnt;
  logic              wdt_timeout;

  // A kick in the would-be timeout cycle cancels the timeout.
  assign wdt_timeout = wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HOLD;
      sync        <= 2'b00;
      stretch_cnt <= '0;
      wdt_cnt     <= '0;
      sopc_rst    <= 1'b1;
      rst_cause   <= 2'b00;
      rst_count   <= 8'd0;
    end else begin
      sync <= {sync[0], 1'b1};
      case (state)
        HOLD: begin
          // Leave HOLD on the edge where the second flop captures its 1.
          if (sync == 2'b01) begin
            state <= STRETCH;
          end
        end
        STRETCH: begin
          wdt_cnt <= '0;
          if (stretch_cnt == STRETCH_LAST) begin
            state       <= RUN;
            stretch_cnt <= '0;
            sopc_rst    <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt + 1'b1;
          end
        end
        RUN: begin
          if (sw_rst_req || wdt_timeout) begin
            state       <= STRETCH;
            sopc_rst    <= 1'b1;
            stretch_cnt <= '0;
            wdt_cnt     <= '0;
            rst_cause   <= sw_rst_req ? 2'b01 : 2'b10;
            if (rst_count != 8'hFF) begin
              rst_count <= rst_count + 8'd1;
            end
          end else if (!wdt_en || wdt_kick) begin
            wdt_cnt <= '0;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
        end
        default: begin
          state       <= STRETCH;
          sopc_rst    <= 1'b1;
          stretch_cnt <= '0;
          wdt_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_rst_ctrl.sv
// Directed bench for sopc_rst_ctrl with a short watchdog (8 cycles) and the default 16-cycle stretch.
module tb_sopc_rst_ctrl;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       sopc_rst;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  sopc_rst_ctrl #(
    .STRETCH_CYCLES(16),
    .WDT_CYCLES    (8),
    .WDT_CW        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .sopc_rst  (sopc_rst),
    .rst_cause (rst_cause),
    .rst_count (rst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    wdt_en     = 1'b0;
    wdt_kick   = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("por_rst_async", sopc_rst, 1);
    chk("por_cause", rst_cause, 0);
    chk("por_count", rst_count, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("por_hold", sopc_rst, 1);
    end
    #3 rst = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("por_release", sopc_rst, (e < 18) ? 1 : 0);
    end
    chk("por_cause_run", rst_cause, 0);
    chk("por_count_run", rst_count, 0);

    // Software reset, with a second request during STRETCH that must be ignored.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("sw_assert", sopc_rst, 1);
    chk("sw_cause", rst_cause, 1);
    chk("sw_count", rst_count, 1);
    for (int k = 1; k <= 16; k++) begin
      sw_rst_req = (k == 3);
      tick();
      sw_rst_req = 1'b0;
      chk("sw_width", sopc_rst, (k < 16) ? 1 : 0);
    end
    chk("sw_ignored_count", rst_count, 1);
    chk("sw_ignored_cause", rst_cause, 1);

    // Watchdog timeout with no kicks from RUN entry.
    wdt_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("wdt_timeout", sopc_rst, (k == 8) ? 1 : 0);
    end
    chk("wdt_cause", rst_cause, 2);
    chk("wdt_count", rst_count, 2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("wdt_width", sopc_rst, (k < 16) ? 1 : 0);
    end

    // Kick every 7 cycles: never reaches the timeout.
    for (int k = 1; k <= 100; k++) begin
      wdt_kick = (k % 7 == 0);
      tick();
      wdt_kick = 1'b0;
      chk("kick_periodic", sopc_rst, 0);
    end

    // Kick exactly in the timeout cycle.
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wdt_kick = (k == 8);
      tick();
      wdt_kick = 1'b0;
      chk("kick_at_timeout", sopc_rst, 0);
    end
    chk("kick_count", rst_count, 2);

    // Software request in the timeout cycle.
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    repeat (7) tick();
    chk("simul_pre", sopc_rst, 0);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("simul_assert", sopc_rst, 1);
    chk("simul_cause", rst_cause, 1);
    chk("simul_count", rst_count, 3);
    repeat (16) tick();
    chk("simul_release", sopc_rst, 0);

    // External reset during STRETCH of a watchdog reset.
    repeat (8) tick();
    chk("mid_wdt_assert", sopc_rst, 1);
    chk("mid_wdt_cause", rst_cause, 2);
    chk("mid_wdt_count", rst_count, 4);
    repeat (4) tick();
    wdt_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_async", sopc_rst, 1);
    chk("mid_rst_cause", rst_cause, 0);
    chk("mid_rst_count", rst_count, 0);
    repeat (3) tick();
    chk("mid_hold", sopc_rst, 1);
    #3 rst = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("mid_release", sopc_rst, (e < 18) ? 1 : 0);
    end

    // Saturating reset counter.
    exp_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      if (exp_cnt < 255) exp_cnt++;
      chk("sat_count", rst_count, exp_cnt);
      repeat (16) tick();
    end
    chk("sat_final_count", rst_count, 255);
    chk("sat_final_cause", rst_cause, 1);
    chk("sat_final_rst", sopc_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
